// File: rtl/coin_acceptor_if.sv
// coin_acceptor_if
// Groups the coin-validator signals exchanged between the slot sensor /
// vending controller side (master) and the coin_acceptor (slave).
//
// Signals:
//   coin_sense  master->slave  raw asynchronous beam-blocked level (1 = coin)
//   accept_en   master->slave  vending FSM can take credit
//   rs5         slave->master  one-cycle 5-coin token
//   rs10        slave->master  one-cycle 10-coin token
//   reject      slave->master  one-cycle reject-gate pulse
//   jam         slave->master  level, high while a jam is active
//   coin_cnt    slave->master  saturating token count   (COIN_ACCEPTOR_STATS_EN)
//   reject_cnt  slave->master  saturating reject count  (COIN_ACCEPTOR_STATS_EN)
//
// Optional feature macro: COIN_ACCEPTOR_STATS_EN
interface coin_acceptor_if;
    logic       coin_sense;
    logic       accept_en;
    logic       rs5;
    logic       rs10;
    logic       reject;
    logic       jam;
`ifdef COIN_ACCEPTOR_STATS_EN
    logic [7:0] coin_cnt;
    logic [7:0] reject_cnt;
`endif

    modport master (
        output coin_sense,
        output accept_en,
`ifdef COIN_ACCEPTOR_STATS_EN
        input  coin_cnt,
        input  reject_cnt,
`endif
        input  rs5,
        input  rs10,
        input  reject,
        input  jam
    );

    modport slave (
        input  coin_sense,
        input  accept_en,
`ifdef COIN_ACCEPTOR_STATS_EN
        output coin_cnt,
        output reject_cnt,
`endif
        output rs5,
        output rs10,
        output reject,
        output jam
    );
endinterface

// File: rtl/coin_acceptor.sv
// coin_acceptor
// Coin-validator front end. Synchronises and debounces the raw optical
// coin sensor, measures how many cycles each coin blocks the beam, and
// classifies it into a one-cycle rs5 / rs10 token or a reject pulse.
// Coins that block the beam for TIMEOUT cycles are declared jammed.
//
// Ports:
//   clk      input   single clock, rising edge
//   reset_n  input   asynchronous active-low reset
//   bus      slave modport of coin_acceptor_if
//            (coin_sense, accept_en in; rs5, rs10, reject, jam out;
//             coin_cnt, reject_cnt out when COIN_ACCEPTOR_STATS_EN)
//
// Optional feature macro: COIN_ACCEPTOR_STATS_EN adds saturating 8-bit
// token and reject counters.
//
// Legal configuration: W5_MAX < W10_MIN, W10_MAX < TIMEOUT,
// TIMEOUT < 2**CNT_W.
module coin_acceptor #(
    parameter int DEB_CYCLES = 3,
    parameter int W5_MIN     = 20,
    parameter int W5_MAX     = 40,
    parameter int W10_MIN    = 60,
    parameter int W10_MAX    = 90,
    parameter int TIMEOUT    = 255,
    parameter int GAP_CYCLES = 10,
    parameter int CNT_W      = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    coin_acceptor_if.slave bus
);

    // Debounce and gap counters only need to reach (N-1).
    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_GAP      = 3'd0,
        ST_IDLE     = 3'd1,
        ST_MEASURE  = 3'd2,
        ST_CLASSIFY = 3'd3,
        ST_JAM      = 3'd4
    } state_t;

    logic             sync1_r;
    logic             sync_r;
    logic             filt_r;
    logic [DEB_W-1:0] deb_cnt_r;

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] width_r;
    logic [CNT_W-1:0] width_s;
    logic [GAP_W-1:0] gap_r;
    logic [GAP_W-1:0] gap_s;

    logic             rs5_r;
    logic             rs5_s;
    logic             rs10_r;
    logic             rs10_s;
    logic             reject_r;
    logic             reject_s;
    logic             jam_r;
    logic             jam_s;

    logic             in_w5_s;
    logic             in_w10_s;

    // Two-flop synchroniser followed by the stability-count debounce filter.
    // Rising and falling transitions take the same path, so the filtered
    // pulse has exactly the raw width for clean pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r   <= 1'b0;
            sync_r    <= 1'b0;
            filt_r    <= 1'b0;
            deb_cnt_r <= DEB_W'(0);
        end else begin
            sync1_r <= bus.coin_sense;
            sync_r  <= sync1_r;
            if (sync_r != filt_r) begin
                if (deb_cnt_r == DEB_LAST) begin
                    filt_r    <= sync_r;
                    deb_cnt_r <= DEB_W'(0);
                end else begin
                    deb_cnt_r <= deb_cnt_r + DEB_W'(1);
                end
            end else begin
                deb_cnt_r <= DEB_W'(0);
            end
        end
    end

    // Width window decode on the measured width.
    always_comb begin
        in_w5_s  = (width_r >= CNT_W'(W5_MIN))  && (width_r <= CNT_W'(W5_MAX));
        in_w10_s = (width_r >= CNT_W'(W10_MIN)) && (width_r <= CNT_W'(W10_MAX));
    end

    // Next-state, counter and next-output logic of the coin FSM.
    always_comb begin
        state_s  = state_r;
        width_s  = width_r;
        gap_s    = gap_r;
        rs5_s    = 1'b0;
        rs10_s   = 1'b0;
        reject_s = 1'b0;
        jam_s    = jam_r;
        case (state_r)
            ST_GAP: begin
                if (filt_r) begin
                    gap_s = GAP_W'(0);
                end else if (gap_r == GAP_LAST) begin
                    gap_s   = GAP_W'(0);
                    state_s = ST_IDLE;
                end else begin
                    gap_s = gap_r + GAP_W'(1);
                end
            end
            ST_IDLE: begin
                if (filt_r) begin
                    width_s = CNT_W'(1);
                    state_s = ST_MEASURE;
                end else begin
                    width_s = CNT_W'(0);
                end
            end
            ST_MEASURE: begin
                if (filt_r) begin
                    // Capping at TIMEOUT is what keeps the counter from wrapping.
                    if (width_r == TO_LAST) begin
                        width_s  = CNT_W'(TIMEOUT);
                        state_s  = ST_JAM;
                        reject_s = 1'b1;
                        jam_s    = 1'b1;
                    end else begin
                        width_s = width_r + CNT_W'(1);
                    end
                end else begin
                    state_s = ST_CLASSIFY;
                end
            end
            ST_CLASSIFY: begin
                // accept_en only matters in this single cycle.
                state_s = ST_GAP;
                gap_s   = GAP_W'(0);
                if (bus.accept_en && in_w5_s) begin
                    rs5_s = 1'b1;
                end else if (bus.accept_en && in_w10_s) begin
                    rs10_s = 1'b1;
                end else begin
                    reject_s = 1'b1;
                end
            end
            ST_JAM: begin
                if (!filt_r) begin
                    jam_s   = 1'b0;
                    state_s = ST_GAP;
                    gap_s   = GAP_W'(0);
                end else begin
                    jam_s = 1'b1;
                end
            end
            default: begin
                state_s = ST_GAP;
                width_s = CNT_W'(0);
                gap_s   = GAP_W'(0);
                jam_s   = 1'b0;
            end
        endcase
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= ST_GAP;
            width_r  <= CNT_W'(0);
            gap_r    <= GAP_W'(0);
            rs5_r    <= 1'b0;
            rs10_r   <= 1'b0;
            reject_r <= 1'b0;
            jam_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            width_r  <= width_s;
            gap_r    <= gap_s;
            rs5_r    <= rs5_s;
            rs10_r   <= rs10_s;
            reject_r <= reject_s;
            jam_r    <= jam_s;
        end
    end

    assign bus.rs5    = rs5_r;
    assign bus.rs10   = rs10_r;
    assign bus.reject = reject_r;
    assign bus.jam    = jam_r;

`ifdef COIN_ACCEPTOR_STATS_EN
    logic [7:0] coin_cnt_r;
    logic [7:0] reject_cnt_r;

    // Saturating tallies of issued tokens and reject pulses (jams included).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            coin_cnt_r   <= 8'd0;
            reject_cnt_r <= 8'd0;
        end else begin
            if ((rs5_r || rs10_r) && (coin_cnt_r != 8'hFF)) begin
                coin_cnt_r <= coin_cnt_r + 8'd1;
            end else begin
                coin_cnt_r <= coin_cnt_r;
            end
            if (reject_r && (reject_cnt_r != 8'hFF)) begin
                reject_cnt_r <= reject_cnt_r + 8'd1;
            end else begin
                reject_cnt_r <= reject_cnt_r;
            end
        end
    end

    assign bus.coin_cnt   = coin_cnt_r;
    assign bus.reject_cnt = reject_cnt_r;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
`timescale 1ns/1ps
module tb_coin_acceptor;

    localparam int DEB     = 3;
    localparam int W5_MIN  = 20;
    localparam int W5_MAX  = 40;
    localparam int W10_MIN = 60;
    localparam int W10_MAX = 90;
    localparam int TIMEOUT = 255;
    localparam int MAXC    = 30000;

    localparam int O_NONE = 0;
    localparam int O_RS5  = 1;
    localparam int O_RS10 = 2;
    localparam int O_REJ  = 3;
    localparam int O_JAM  = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;

    coin_acceptor_if bus ();

    coin_acceptor dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // Rising-edge index: after edge n, cyc == n.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected output value for each observed cycle (sampled on negedge).
    bit exp_rs5  [MAXC];
    bit exp_rs10 [MAXC];
    bit exp_rej  [MAXC];
    bit exp_jam  [MAXC];

    int vectors     = 0;
    int miscompares = 0;
    int fail_lines  = 0;
    int n_rs5       = 0;
    int n_rs10      = 0;
    int n_rej       = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            if (fail_lines < 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
            fail_lines++;
        end
    endtask

    // Cycle-accurate comparison of {jam, reject, rs10, rs5} against the schedule.
    always @(negedge clk) begin
        if (cyc < MAXC) begin
            check($sformatf("outputs{jam,rej,rs10,rs5} cyc %0d", cyc),
                  {28'd0, bus.jam, bus.reject, bus.rs10, bus.rs5},
                  {28'd0, exp_jam[cyc], exp_rej[cyc], exp_rs10[cyc], exp_rs5[cyc]});
        end
        n_rs5  += int'(bus.rs5);
        n_rs10 += int'(bus.rs10);
        n_rej  += int'(bus.reject);
    end

    // Reference model: outcome of one clean coin of raw width w.
    function automatic int model(input int w, input bit acc);
        if (w < DEB)                           return O_NONE;
        if (w >= TIMEOUT)                      return O_JAM;
        if (!acc)                              return O_REJ;
        if (w >= W5_MIN && w <= W5_MAX)        return O_RS5;
        if (w >= W10_MIN && w <= W10_MAX)      return O_RS10;
        return O_REJ;
    endfunction

    // r = first edge sampling sense high, f = first edge sampling it low.
    task automatic schedule(input int o, input int r, input int f);
        case (o)
            O_RS5:  exp_rs5[f + DEB + 3]  = 1'b1;
            O_RS10: exp_rs10[f + DEB + 3] = 1'b1;
            O_REJ:  exp_rej[f + DEB + 3]  = 1'b1;
            O_JAM: begin
                exp_rej[r + DEB + 1 + TIMEOUT] = 1'b1;
                for (int c = r + DEB + 1 + TIMEOUT; c <= f + DEB + 1; c++) exp_jam[c] = 1'b1;
            end
            default: ;
        endcase
    endtask

    // One clean coin: high for w cycles (accept_en random meanwhile), then low.
    task automatic coin(input int w, input bit acc, input int low, input int exp_o, input string name);
        int r;
        int b5;
        int b10;
        int bj;
        @(negedge clk);
        b5  = n_rs5;
        b10 = n_rs10;
        bj  = n_rej;
        bus.coin_sense = 1'b1;
        r = cyc + 1;
        schedule(exp_o, r, r + w);
        for (int i = 0; i < w; i++) begin
            bus.accept_en = ($urandom_range(0, 1) == 1);
            @(negedge clk);
        end
        bus.coin_sense = 1'b0;
        bus.accept_en  = acc;
        repeat (low) @(negedge clk);
        #1;
        check({name, " rs5 count"},    n_rs5 - b5,  (exp_o == O_RS5)  ? 1 : 0);
        check({name, " rs10 count"},   n_rs10 - b10, (exp_o == O_RS10) ? 1 : 0);
        check({name, " reject count"}, n_rej - bj,
              (exp_o == O_REJ || exp_o == O_JAM) ? 1 : 0);
    endtask

    typedef struct {
        int w;
        bit acc;
        int exp_o;
    } vec_t;

    vec_t tbl [18];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int r;
        int f;
        int w;
        bit acc;
        tbl[0]  = '{30,  1'b1, O_RS5};
        tbl[1]  = '{75,  1'b1, O_RS10};
        tbl[2]  = '{60,  1'b1, O_RS10};
        tbl[3]  = '{90,  1'b1, O_RS10};
        tbl[4]  = '{41,  1'b1, O_REJ};
        tbl[5]  = '{59,  1'b1, O_REJ};
        tbl[6]  = '{50,  1'b1, O_REJ};
        tbl[7]  = '{19,  1'b1, O_REJ};
        tbl[8]  = '{20,  1'b1, O_RS5};
        tbl[9]  = '{40,  1'b1, O_RS5};
        tbl[10] = '{30,  1'b0, O_REJ};
        tbl[11] = '{30,  1'b1, O_RS5};
        tbl[12] = '{75,  1'b0, O_REJ};
        tbl[13] = '{254, 1'b1, O_REJ};
        tbl[14] = '{255, 1'b1, O_JAM};
        tbl[15] = '{300, 1'b1, O_JAM};
        tbl[16] = '{2,   1'b1, O_NONE};
        tbl[17] = '{3,   1'b1, O_REJ};

        bus.coin_sense = 1'b0;
        bus.accept_en  = 1'b0;
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset outputs", {bus.jam, bus.reject, bus.rs10, bus.rs5}, 4'b0000);
`ifdef COIN_ACCEPTOR_STATS_EN
        check("reset coin_cnt", bus.coin_cnt, 8'd0);
        check("reset reject_cnt", bus.reject_cnt, 8'd0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        repeat (15) @(negedge clk);

        for (int i = 0; i < 18; i++)
            coin(tbl[i].w, tbl[i].acc, 25, tbl[i].exp_o, $sformatf("tbl%0d w=%0d", i, tbl[i].w));

        // 30-cycle coin with a 1-cycle dropout after 14 high cycles.
        @(negedge clk);
        bus.accept_en  = 1'b1;
        bus.coin_sense = 1'b1;
        r = cyc + 1;
        repeat (14) @(negedge clk);
        bus.coin_sense = 1'b0;
        @(negedge clk);
        bus.coin_sense = 1'b1;
        repeat (15) @(negedge clk);
        bus.coin_sense = 1'b0;
        f = cyc + 1;
        check("dropout span", f - r, 30);
        schedule(O_RS5, r, f);
        repeat (25) @(negedge clk);

        // Reset while jammed: jam must drop without a clock edge.
        @(negedge clk);
        bus.coin_sense = 1'b1;
        r = cyc + 1;
        exp_rej[r + DEB + 1 + TIMEOUT] = 1'b1;
        for (int c = r + DEB + 1 + TIMEOUT; c <= r + 269; c++) exp_jam[c] = 1'b1;
        repeat (270) @(negedge clk);
        #1;
        check("jam before reset", bus.jam, 1'b1);
        #1 reset_n = 1'b0;
        #1;
        check("jam async clear", {bus.jam, bus.reject, bus.rs10, bus.rs5}, 4'b0000);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        bus.coin_sense = 1'b0;
        repeat (25) @(negedge clk);

        // Reset 10 cycles into a coin, sense kept high afterwards.
        @(negedge clk);
        bus.coin_sense = 1'b1;
        repeat (10) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("reset mid coin outputs", {bus.jam, bus.reject, bus.rs10, bus.rs5}, 4'b0000);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        bus.coin_sense = 1'b0;
        repeat (25) @(negedge clk);
        coin(30, 1'b1, 25, O_RS5, "post reset coin");
`ifdef COIN_ACCEPTOR_STATS_EN
        check("stats coin_cnt", bus.coin_cnt, 8'd1);
        check("stats reject_cnt", bus.reject_cnt, 8'd0);
`endif

        // Randomized coins against the reference model.
        for (int i = 0; i < 40; i++) begin
            w   = ($urandom_range(0, 9) == 0) ? $urandom_range(250, 260) : $urandom_range(1, 120);
            acc = ($urandom_range(0, 3) != 0);
            coin(w, acc, $urandom_range(18, 40), model(w, acc), $sformatf("rnd%0d w=%0d acc=%0d", i, w, acc));
        end

        repeat (5) @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
